// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads win every slot, then one posted CPU
// write, then CPU reads. A saturating wait counter flags starved CPU requests.
module vram_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              vid_req_i,
  input  logic [ADDR_W-1:0] vid_addr_i,
  output logic              vid_valid_o,
  output logic [DATA_W-1:0] vid_data_o,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_ack_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  output logic              cpu_starved_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);

  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              wb_valid_q, wb_valid_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              rd_pend_q, rd_pend_d;
  logic              s1_vld_q, s1_vld_d;
  logic              s1_cpu_q, s1_cpu_d;
  logic              s2_vld_q, s2_vld_d;
  logic              s2_cpu_q, s2_cpu_d;
  logic              vid_valid_q, vid_valid_d;
  logic [DATA_W-1:0] vid_data_q, vid_data_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [7:0]        starve_cnt_q, starve_cnt_d;
  logic              starved_q, starved_d;
  logic              wr_accept, rd_eligible, rd_done;

  always_comb begin
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    wb_valid_d   = wb_valid_q;
    wb_addr_d    = wb_addr_q;
    wb_data_d    = wb_data_q;
    rd_pend_d    = rd_pend_q;
    s1_vld_d     = 1'b0;
    s1_cpu_d     = 1'b0;
    s2_vld_d     = s1_vld_q;
    s2_cpu_d     = s1_cpu_q;
    vid_valid_d  = 1'b0;
    vid_data_d   = vid_data_q;
    cpu_ack_d    = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    starve_cnt_d = 8'd0;
    starved_d    = 1'b0;

    // cpu_ack_q blocks re-acceptance while the CPU still holds the finished request
    wr_accept   = cpu_req_i & cpu_we_i & ~wb_valid_q & ~cpu_ack_q;
    rd_eligible = cpu_req_i & ~cpu_we_i & ~wb_valid_q & ~rd_pend_q & ~cpu_ack_q;
    rd_done     = s2_vld_q & s2_cpu_q;

    if (s2_vld_q && !s2_cpu_q) begin
      vid_valid_d = 1'b1;
      vid_data_d  = mem_rdata_i;
    end
    if (rd_done) begin
      cpu_ack_d   = 1'b1;
      cpu_rdata_d = mem_rdata_i;
      rd_pend_d   = 1'b0;
    end

    if (vid_req_i) begin
      mem_en_d   = 1'b1;
      mem_addr_d = vid_addr_i;
      s1_vld_d   = 1'b1;
    end else if (wb_valid_q) begin
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b1;
      mem_addr_d  = wb_addr_q;
      mem_wdata_d = wb_data_q;
      wb_valid_d  = 1'b0;
    end else if (rd_eligible) begin
      mem_en_d   = 1'b1;
      mem_addr_d = cpu_addr_i;
      s1_vld_d   = 1'b1;
      s1_cpu_d   = 1'b1;
      rd_pend_d  = 1'b1;
    end

    // accept only needs an empty buffer, so it never collides with a drain
    if (wr_accept) begin
      wb_valid_d = 1'b1;
      wb_addr_d  = cpu_addr_i;
      wb_data_d  = cpu_wdata_i;
      cpu_ack_d  = 1'b1;
    end

    if (cpu_req_i && !cpu_ack_q) begin
      starve_cnt_d = (starve_cnt_q == 8'hFF) ? starve_cnt_q : starve_cnt_q + 8'd1;
    end
    starved_d = (starve_cnt_d >= STARVE_LIM);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
      rd_pend_q    <= 1'b0;
      s1_vld_q     <= 1'b0;
      s1_cpu_q     <= 1'b0;
      s2_vld_q     <= 1'b0;
      s2_cpu_q     <= 1'b0;
      vid_valid_q  <= 1'b0;
      vid_data_q   <= '0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      starve_cnt_q <= 8'd0;
      starved_q    <= 1'b0;
    end else begin
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
      rd_pend_q    <= rd_pend_d;
      s1_vld_q     <= s1_vld_d;
      s1_cpu_q     <= s1_cpu_d;
      s2_vld_q     <= s2_vld_d;
      s2_cpu_q     <= s2_cpu_d;
      vid_valid_q  <= vid_valid_d;
      vid_data_q   <= vid_data_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      starve_cnt_q <= starve_cnt_d;
      starved_q    <= starved_d;
    end
  end

  assign vid_valid_o   = vid_valid_q;
  assign vid_data_o    = vid_data_q;
  assign cpu_ack_o     = cpu_ack_q;
  assign cpu_rdata_o   = cpu_rdata_q;
  assign cpu_starved_o = starved_q;
  assign mem_en_o      = mem_en_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: synchronous RAM model, completion-queue reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_vram_arbiter;

  localparam int LIMIT = 16;

  logic        clk, rst_n;
  logic        vid_req, vid_valid, cpu_req, cpu_we, cpu_ack, cpu_starved;
  logic        mem_en, mem_we;
  logic [15:0] vid_addr, vid_data, cpu_addr, cpu_wdata, cpu_rdata;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  vram_arbiter #(.ADDR_W(16), .DATA_W(16), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .vid_req_i(vid_req), .vid_addr_i(vid_addr), .vid_valid_o(vid_valid), .vid_data_o(vid_data),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(cpu_ack), .cpu_rdata_o(cpu_rdata), .cpu_starved_o(cpu_starved),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous VRAM
  logic [15:0] ram [0:65535];
  initial mem_rdata = 16'h0;
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // reference model: a queue of completions, each due a fixed number of edges after its slot
  typedef struct { int due; bit is_cpu; logic [15:0] data; } rd_t;
  rd_t         rq[$];
  logic [15:0] ref_mem [0:65535];
  int          cyc = 0;
  int          m_cnt;
  logic        m_wb_v, m_rd_pend, m_ack, m_vvalid, m_starved, m_mem_en, m_mem_we;
  logic [15:0] m_wb_a, m_wb_d, m_rdata, m_vdata, m_mem_addr, m_mem_wdata;

  always @(posedge clk) begin
    logic old_ack, old_wb, old_pend;
    rd_t  e;
    if (!rst_n) begin
      rq.delete();
      m_cnt = 0; m_wb_v = 0; m_rd_pend = 0; m_ack = 0; m_vvalid = 0; m_starved = 0;
      m_mem_en = 0; m_mem_we = 0; m_wb_a = 0; m_wb_d = 0; m_rdata = 0; m_vdata = 0;
      m_mem_addr = 0; m_mem_wdata = 0;
    end else begin
      old_ack = m_ack; old_wb = m_wb_v; old_pend = m_rd_pend;
      cyc++;
      if (cpu_req && !old_ack) m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      else                     m_cnt = 0;
      m_starved = (m_cnt >= LIMIT);
      m_ack = 0; m_vvalid = 0;
      while (rq.size() > 0 && rq[0].due == cyc) begin
        e = rq.pop_front();
        if (e.is_cpu) begin m_ack = 1; m_rdata = e.data; m_rd_pend = 0; end
        else          begin m_vvalid = 1; m_vdata = e.data; end
      end
      m_mem_en = 0; m_mem_we = 0;
      if (vid_req) begin
        m_mem_en = 1; m_mem_addr = vid_addr;
        rq.push_back('{cyc + 2, 1'b0, ref_mem[vid_addr]});
      end else if (old_wb) begin
        m_mem_en = 1; m_mem_we = 1; m_mem_addr = m_wb_a; m_mem_wdata = m_wb_d;
        ref_mem[m_wb_a] = m_wb_d; m_wb_v = 0;
      end else if (cpu_req && !cpu_we && !old_pend && !old_ack) begin
        m_mem_en = 1; m_mem_addr = cpu_addr; m_rd_pend = 1;
        rq.push_back('{cyc + 2, 1'b1, ref_mem[cpu_addr]});
      end
      if (cpu_req && cpu_we && !old_wb && !old_ack) begin
        m_wb_v = 1; m_wb_a = cpu_addr; m_wb_d = cpu_wdata; m_ack = 1;
      end
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h, want 0x%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d @%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk1 ("mdl_mem_en", mem_en, m_mem_en);
      chk1 ("mdl_mem_we", mem_we, m_mem_we);
      chk16("mdl_mem_addr", mem_addr, m_mem_addr);
      if (m_mem_we) chk16("mdl_mem_wdata", mem_wdata, m_mem_wdata);
      chk1 ("mdl_vid_valid", vid_valid, m_vvalid);
      chk16("mdl_vid_data", vid_data, m_vdata);
      chk1 ("mdl_cpu_ack", cpu_ack, m_ack);
      chk16("mdl_cpu_rdata", cpu_rdata, m_rdata);
      chk1 ("mdl_starved", cpu_starved, m_starved);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_in();
    vid_req = 0; vid_addr = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
  endtask

  // waits for cpu_ack with a bounded budget; lat = -1 on timeout
  task automatic txn(output int lat);
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_ack) begin lat = i; break; end
      step();
    end
    step();
    cpu_req = 0;
  endtask

  initial begin
    int   lat;
    logic ack_seen;
    for (int i = 0; i < 65536; i++) begin
      ram[i]     = 16'(i) ^ 16'hA5A5;
      ref_mem[i] = 16'(i) ^ 16'hA5A5;
    end
    rst_n = 0;
    idle_in();
    step();

    // reset values with random inputs
    for (int k = 0; k < 5; k++) begin
      vid_req = 1'($urandom); vid_addr = 16'($urandom); cpu_req = 1'($urandom);
      cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
      @(negedge clk);
      chk1("rst_vid_valid", vid_valid, 0); chk16("rst_vid_data", vid_data, 0);
      chk1("rst_cpu_ack", cpu_ack, 0);     chk16("rst_cpu_rdata", cpu_rdata, 0);
      chk1("rst_starved", cpu_starved, 0); chk1("rst_mem_en", mem_en, 0);
      chk1("rst_mem_we", mem_we, 0);       chk16("rst_mem_addr", mem_addr, 0);
      chk16("rst_mem_wdata", mem_wdata, 0);
      step();
    end
    idle_in();
    rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); chk1("post_rst_mem_en", mem_en, 0); step();
    end

    // video streaming
    for (int k = 0; k < 13; k++) begin
      vid_req = (k < 8); vid_addr = 16'(16'h0100 + k);
      @(negedge clk);
      chk1("vs_valid", vid_valid, (k >= 3 && k <= 10));
      if (k >= 3 && k <= 10) chk16("vs_data", vid_data, 16'(16'h0100 + k - 3) ^ 16'hA5A5);
      if (k == 3)  chk16("vs_first", vid_data, 16'hA4A5);
      if (k == 10) chk16("vs_last", vid_data, 16'hA4A2);
      step();
    end
    idle_in();

    // idle write then read
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0042; cpu_wdata = 16'hBEEF;
    txn(lat);
    chki("wr_ack_lat", lat, 1);
    @(negedge clk);
    chk1("wr_mem_en", mem_en, 1); chk1("wr_mem_we", mem_we, 1);
    chk16("wr_mem_addr", mem_addr, 16'h0042); chk16("wr_mem_wdata", mem_wdata, 16'hBEEF);
    step();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0042;
    txn(lat);
    chki("rd_ack_lat", lat, 3);
    chk16("rd_rdata", cpu_rdata, 16'hBEEF);
    repeat (3) step();

    // CPU read under continuous video
    for (int k = 0; k < 26; k++) begin
      vid_req = (k < 20); vid_addr = 16'(16'h0300 + k);
      cpu_req = (k < 24); cpu_we = 0; cpu_addr = 16'h0010;
      @(negedge clk);
      chk1("rv_mem_en", mem_en, (k >= 1 && k <= 21));
      if (k >= 1 && k <= 20) chk16("rv_vid_slot", mem_addr, 16'(16'h0300 + k - 1));
      if (k == 21) chk16("rv_cpu_slot", mem_addr, 16'h0010);
      chk1("rv_ack", cpu_ack, (k == 23));
      if (k == 23) chk16("rv_rdata", cpu_rdata, 16'hA5B5);
      chk1("rv_starved", cpu_starved, (k >= 16 && k <= 23));
      step();
    end
    idle_in();
    repeat (2) step();

    // posted write drains in first video gap, ahead of the following read
    for (int k = 0; k < 18; k++) begin
      vid_req = (k <= 11 && k != 6); vid_addr = 16'(16'h0400 + k);
      cpu_req = (k >= 1 && k <= 15); cpu_we = (k <= 2);
      cpu_addr = 16'h0200; cpu_wdata = 16'h1234;
      @(negedge clk);
      chk1("pw_ack", cpu_ack, (k == 2 || k == 15));
      chk1("pw_mem_we", mem_we, (k == 7));
      if (k == 7) begin
        chk16("pw_mem_addr", mem_addr, 16'h0200); chk16("pw_mem_wdata", mem_wdata, 16'h1234);
      end
      if (k == 13) chk16("pw_rd_slot", mem_addr, 16'h0200);
      if (k == 15) chk16("pw_rdata", cpu_rdata, 16'h1234);
      chk1("pw_vvalid", vid_valid, ((k >= 3 && k <= 8) || (k >= 10 && k <= 14)));
      if ((k >= 3 && k <= 8) || (k >= 10 && k <= 14))
        chk16("pw_vdata", vid_data, 16'(16'h0400 + k - 3) ^ 16'hA5A5);
      step();
    end
    idle_in();
    repeat (2) step();

    // randomized traffic, CPU obeys hold-until-ack
    ack_seen = 0;
    for (int c = 0; c < 3000; c++) begin
      vid_req  = ($urandom_range(0, 9) < (((c / 200) % 2 == 1) ? 9 : 4));
      vid_addr = 16'($urandom_range(0, 47));
      if (cpu_req && ack_seen) cpu_req = 0;
      else if (!cpu_req && $urandom_range(0, 2) == 0) begin
        cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = 16'($urandom_range(0, 47));
        cpu_wdata = 16'($urandom);
      end
      @(negedge clk); ack_seen = cpu_ack;
      step();
    end
    vid_req = 0;
    for (int c = 0; c < 20; c++) begin
      if (cpu_req && ack_seen) cpu_req = 0;
      @(negedge clk); ack_seen = cpu_ack;
      step();
    end
    idle_in();
    repeat (3) step();

    // reset with a video read and a CPU read in flight
    vid_req = 1; vid_addr = 16'h0500; cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0020;
    step();
    vid_req = 0;
    step();
    chk1("rm_rd_issued", mem_en, 1); chk16("rm_rd_addr", mem_addr, 16'h0020);
    rst_n = 0; idle_in();
    repeat (3) step();
    rst_n = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk1("rm_ack", cpu_ack, 0); chk1("rm_vvalid", vid_valid, 0); chk1("rm_mem_en", mem_en, 0);
      step();
    end

    // reset with an acknowledged write still buffered behind video
    vid_req = 1; vid_addr = 16'h0501; cpu_req = 1; cpu_we = 1;
    cpu_addr = 16'h0600; cpu_wdata = 16'h5555;
    step();
    @(negedge clk); chk1("rw_ack", cpu_ack, 1);
    step();
    cpu_req = 0;
    chk1("rw_buffered", dut.wb_valid_q, 1);
    rst_n = 0; idle_in();
    repeat (3) step();
    rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); chk1("rw_mem_en", mem_en, 0); step();
    end
    chk1("rw_wb_cleared", dut.wb_valid_q, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video RAM arbiter between the VGA scanout fetcher and the CPU bus. Scanout reads have absolute priority. CPU writes are posted through a one-entry write buffer, and CPU reads use the free RAM slots. It sits between the video timing/pixel fetch logic and the synchronous VRAM inside `top`, and reports CPU starvation for debug (e.g. on `leds`).

## Interface

- `ADDR_W`, 16, VRAM word address width
- `DATA_W`, 16, VRAM word width
- `STARVE_LIMIT`, 16, pending-cycle count at which `cpu_starved` asserts; 1..255

- `clk`  in  1  system clock, all logic on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `vid_req`  in  1  scanout read request, one word per cycle it is high
- `vid_addr`  in  ADDR_W  scanout read address, sampled with `vid_req`
- `vid_valid`  out  1  scanout read data valid, one pulse per request
- `vid_data`  out  DATA_W  scanout read data
- `cpu_req`  in  1  CPU request; level, held with stable fields until `cpu_ack`
- `cpu_we`  in  1  1 = write, 0 = read
- `cpu_addr`  in  ADDR_W  CPU address
- `cpu_wdata`  in  DATA_W  CPU write data
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_rdata`  out  DATA_W  CPU read data, valid with `cpu_ack` for reads
- `cpu_starved`  out  1  CPU request pending for at least `STARVE_LIMIT` cycles
- `mem_en`  out  1  RAM access strobe (registered)
- `mem_we`  out  1  RAM write enable (registered)
- `mem_addr`  out  ADDR_W  RAM address (registered)
- `mem_wdata`  out  DATA_W  RAM write data (registered)
- `mem_rdata`  in  DATA_W  RAM read data, valid the cycle after a read `mem_en`

## Operation

- **Reset.** Reset clears all outputs to 0, the write buffer (`wb_valid`), the read pipeline tags and the starve counter.
  - Reset mid-operation discards in-flight reads: no `vid_valid` or `cpu_ack` is produced for them.
  - An acknowledged write still sitting in the buffer is lost.
- **Slot arbitration.** One RAM slot per cycle, decided at each edge in this fixed priority:
  1. `vid_req`: issue a video read.
  2. Else `wb_valid`: issue the buffered write (`mem_we`=1). `wb_valid` clears at that edge.
  3. Else an accepted CPU read: issue the read.
  4. Else `mem_en`=0. `mem_addr` and `mem_wdata` hold their last values.
- **CPU write acceptance.** A write is accepted at an edge where `cpu_req & cpu_we & !wb_valid & !cpu_ack`. At that edge the address and data load into the buffer. `cpu_ack`=1 the following cycle. Acceptance is independent of video traffic.
- **CPU read acceptance.** A read is eligible when `cpu_req & !cpu_we & !wb_valid & !rd_pending & !cpu_ack`.
  - It issues only in a slot lost by video and the write buffer.
  - A read never passes a buffered write, which gives read-after-write ordering.
  - `rd_pending` is set from issue until `cpu_ack`.
- **Read pipeline.** A 2-stage tag pipeline (video/CPU, valid) follows each read. `mem_rdata` is registered into `vid_data` or `cpu_rdata` according to the tag.
- **Starve counter** (8-bit, saturating at 255):
  - Increments each cycle that `cpu_req` is high and `cpu_ack` is low.
  - Clears in any cycle `cpu_ack` or `!cpu_req`.
  - `cpu_starved` = counter ≥ `STARVE_LIMIT`, registered.
- **Simultaneous events.** If `vid_req` arrives in the same cycle as a pending write or read, video wins and the CPU retries the next cycle. Write acceptance and write drain of the previous entry never occur at the same edge.

## Timing

- **Video read.** `vid_req` sampled at the end of cycle 0 gives:
  - `mem_en` in cycle 1
  - `mem_rdata` in cycle 2
  - `vid_valid`/`vid_data` in cycle 3
- **Video throughput.** 1 word/cycle, in order, with no bubbles inserted.
- **CPU write.** `cpu_ack` 1 cycle after acceptance. RAM write in the first free slot, at best the cycle after the ack.
- **CPU read.** `cpu_ack` 3 cycles after the issue-decision cycle. With no contention, `cpu_req` rising in cycle 0 gives `cpu_ack` in cycle 3.
- **Output widths.** `cpu_ack` and `vid_valid` are exactly 1 cycle wide. `cpu_rdata` and `vid_data` hold until the next respective completion.

## Test plan

- **Reset values.** Hold `rst`=0 for 5 cycles with random inputs, then release with idle inputs → every output is 0 during reset, and `mem_en` stays 0 for 10 cycles after release.
- **Video streaming.** RAM preloaded with data = addr ^ 0xA5A5. `vid_req` high for 8 cycles, `vid_addr` 0x0100..0x0107 → `vid_valid` high for 8 consecutive cycles starting 3 cycles after the first request, carrying data 0xA4A5..0xA4A2 in order.
- **Idle write then read.** CPU write 0x0042 ← 0xBEEF with video idle → `cpu_ack` the next cycle, then one `mem_we` pulse at 0x0042. A following read of 0x0042 → `cpu_ack` with `cpu_rdata`=0xBEEF.
- **Read under continuous video.** `vid_req` held for 20 cycles while a CPU read of 0x0010 is pending → no CPU `mem_en` during video, and `cpu_starved` rises after 16 pending cycles. The read issues in the first cycle after `vid_req` drops, `cpu_ack` follows 3 cycles later, and `cpu_starved` then clears.
- **Posted write under video.** A write to 0x0200 ← 0x1234 is acked during video streaming, and a read of 0x0200 follows immediately → the write drains in the first video gap, before the read. The read returns 0x1234, and the video data stream is unaffected.
- **Reset mid-read.** `rst` asserted 1 cycle after a CPU read issues and a video read issues → no `cpu_ack` or `vid_valid` appears after release, and `wb_valid` is cleared.
